// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the audio sample FIFO slice.
//   DEPTH_DEFAULT      default sample storage depth (power of two)
//   LOW_WATER_DEFAULT  default fill level that starts playback / drives the IRQ
//   SAMPLE_W           PCM sample width
//   sample_t           signed PCM sample
//   fifo_state_e       playback FSM states
// -----------------------------------------------------------------------------
package audio_pkg;

    localparam int DEPTH_DEFAULT     = 256;
    localparam int LOW_WATER_DEFAULT = 64;
    localparam int SAMPLE_W          = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Explicit encodings keep the state register readable in legacy dumps.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRIME   = 2'd1,
        ST_PLAY    = 2'd2,
        ST_STARVED = 2'd3
    } fifo_state_e;

endpackage

// File: rtl/audio_sample_fifo_if.sv
// -----------------------------------------------------------------------------
// audio_sample_fifo_if
// Control/data bundle between the NIOS-II writer, the audio driver and the
// sample FIFO.
//   i_enable        playback enable (low = idle and flushed)
//   i_wr_data       signed PCM sample from the CPU
//   i_wr_en         one-cycle write strobe
//   i_next_sample   one-cycle pop request from the audio driver
//   i_clr_flags     clears the sticky UNDERRUN / OVERFLOW flags
//   o_data          sample presented to the audio driver
//   o_level         occupancy, 0..DEPTH
//   o_full/o_empty  occupancy at DEPTH / at 0
//   o_low_water_irq level interrupt, enabled and below the low-water mark
//   o_underrun      sticky: pop requested while empty during playback
//   o_overflow      sticky: write dropped because the FIFO was full
// Modports: slave = the FIFO, master = the system driving it.
// -----------------------------------------------------------------------------
interface audio_sample_fifo_if
    import audio_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
);

    localparam int LVW = $clog2(DEPTH) + 1;

    logic            i_enable;
    sample_t         i_wr_data;
    logic            i_wr_en;
    logic            i_next_sample;
    logic            i_clr_flags;
    sample_t         o_data;
    logic [LVW-1:0]  o_level;
    logic            o_full;
    logic            o_empty;
    logic            o_low_water_irq;
    logic            o_underrun;
    logic            o_overflow;

    modport slave (
        input  i_enable, i_wr_data, i_wr_en, i_next_sample, i_clr_flags,
        output o_data, o_level, o_full, o_empty, o_low_water_irq,
               o_underrun, o_overflow
    );

    modport master (
        output i_enable, i_wr_data, i_wr_en, i_next_sample, i_clr_flags,
        input  o_data, o_level, o_full, o_empty, o_low_water_irq,
               o_underrun, o_overflow
    );

endinterface

// File: rtl/sample_ram.sv
// -----------------------------------------------------------------------------
// sample_ram
// Simple dual-port RAM, DEPTH x WIDTH, one write port and one synchronous read
// port with read enable, written so block-RAM (M9K) inference applies.
//   Clk        clock
//   i_wr_en    write strobe
//   i_wr_addr  write address
//   i_wr_data  write data
//   i_rd_en    read enable; the output register holds when low
//   i_rd_addr  read address
//   o_rd_data  registered read data, valid one cycle after i_rd_en
// A read and a write to the same address in one cycle returns the old word.
// -----------------------------------------------------------------------------
module sample_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 16
) (
    input  logic                     Clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [WIDTH-1:0]         o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // NOTE: no reset on the array or its read register: a reset would stop the
    // tools from mapping it onto block RAM. The FIFO masks stale contents.
    // NOTE: non-blocking assignments here make a same-address read see the
    // word from before this cycle's write, exactly as the block RAM does.
    always_ff @(posedge Clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/audio_sample_fifo.sv
// -----------------------------------------------------------------------------
// audio_sample_fifo
// Sample buffer between the NIOS-II (writer) and the audio codec driver
// (reader). A four-state FSM primes the buffer up to LOW_WATER before playback,
// pops one sample per NEXT_SAMPLE request while playing, and falls back to a
// starved/re-prime state on underrun. Dropping ENABLE flushes everything.
//   Clk       clock, all registers on the rising edge
//   Reset     synchronous, active-high
//   fifo_bus  audio_sample_fifo_if.slave (see the interface for signals)
// Parameters: DEPTH (power of two), LOW_WATER (playback start / IRQ level).
// -----------------------------------------------------------------------------
module audio_sample_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEFAULT,
    parameter int LOW_WATER = LOW_WATER_DEFAULT
) (
    input  logic                Clk,
    input  logic                Reset,
    audio_sample_fifo_if.slave  fifo_bus
);

    localparam int              AW        = $clog2(DEPTH);
    localparam int              LVW       = AW + 1;
    localparam logic [LVW-1:0]  DEPTH_LVL = LVW'(DEPTH);
    localparam logic [LVW-1:0]  LOW_LVL   = LVW'(LOW_WATER);

    fifo_state_e     r_state;
    fifo_state_e     w_state_next;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LVW-1:0]  r_level;
    logic [LVW-1:0]  w_level_next;
    logic            r_data_valid;
    logic            r_underrun;
    logic            r_overflow;
    sample_t         w_ram_q;

    logic            w_active;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_push;
    logic            w_underrun_evt;
    logic            w_overflow_evt;

    // -------------------------------------------------------------------------
    // Transfer decisions
    // -------------------------------------------------------------------------
    assign w_full   = (r_level == DEPTH_LVL);
    assign w_empty  = (r_level == '0);

    // IDLE and a dropped ENABLE both block all traffic.
    assign w_active = fifo_bus.i_enable && (r_state != ST_IDLE);

    // Pops are honoured only while playing; PRIME/STARVED ignore them.
    assign w_pop          = w_active && (r_state == ST_PLAY) &&
                            fifo_bus.i_next_sample && !w_empty;
    assign w_underrun_evt = w_active && (r_state == ST_PLAY) &&
                            fifo_bus.i_next_sample && w_empty;

    // A pop in the same cycle frees the slot, so a full FIFO still takes it.
    assign w_push         = w_active && fifo_bus.i_wr_en && (!w_full || w_pop);
    assign w_overflow_evt = w_active && fifo_bus.i_wr_en && w_full && !w_pop;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_level_next = r_level;
        if (w_push && !w_pop) begin
            w_level_next = r_level + 1'b1;
        end else if (w_pop && !w_push) begin
            w_level_next = r_level - 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Playback FSM
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (!fifo_bus.i_enable) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_next = ST_PRIME;
                end
                // Look at the post-write level so playback can start on the
                // same edge that lands the LOW_WATER-th sample.
                ST_PRIME, ST_STARVED: begin
                    if (w_level_next >= LOW_LVL) begin
                        w_state_next = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (w_underrun_evt) begin
                        w_state_next = ST_STARVED;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State, pointers, occupancy and flags
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= ST_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_data_valid <= 1'b0;
            r_underrun   <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if (!fifo_bus.i_enable) begin
                // Flush: stored samples are abandoned, the RAM keeps garbage.
                r_wr_ptr     <= '0;
                r_rd_ptr     <= '0;
                r_level      <= '0;
                r_data_valid <= 1'b0;
            end else begin
                // Pointers are AW bits wide and wrap naturally modulo DEPTH.
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                r_level <= w_level_next;

                if (w_pop) begin
                    r_data_valid <= 1'b1;
                end else if (w_underrun_evt) begin
                    r_data_valid <= 1'b0;
                end
            end

            // A new error event beats a same-cycle clear.
            if (w_underrun_evt) begin
                r_underrun <= 1'b1;
            end else if (fifo_bus.i_clr_flags) begin
                r_underrun <= 1'b0;
            end

            if (w_overflow_evt) begin
                r_overflow <= 1'b1;
            end else if (fifo_bus.i_clr_flags) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    sample_ram #(
        .DEPTH (DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_sample_ram (
        .Clk       (Clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (fifo_bus.i_wr_data),
        .i_rd_en   (w_pop),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_ram_q)
    );

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // The RAM read register only loads on a pop, so it already holds DATA
    // between pops; r_data_valid forces zero after reset, flush and underrun
    // without putting a reset on the RAM output register.
    assign fifo_bus.o_data          = r_data_valid ? w_ram_q : '0;
    assign fifo_bus.o_level         = r_level;
    assign fifo_bus.o_full          = w_full;
    assign fifo_bus.o_empty         = w_empty;
    assign fifo_bus.o_low_water_irq = w_active && (r_level < LOW_LVL);
    assign fifo_bus.o_underrun      = r_underrun;
    assign fifo_bus.o_overflow      = r_overflow;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// -----------------------------------------------------------------------------
// tb_audio_sample_fifo
// Directed bench for audio_sample_fifo. A behavioural model tracks occupancy,
// playback state and sticky flags; written samples go into a scoreboard queue
// and are popped and compared whenever the driver requests a sample.
// -----------------------------------------------------------------------------
module tb_audio_sample_fifo;
    import audio_pkg::*;

    localparam int DEPTH = DEPTH_DEFAULT;
    localparam int LW    = LOW_WATER_DEFAULT;

    logic Clk = 1'b0;
    logic Reset;

    always #5 Clk = ~Clk;

    audio_sample_fifo_if #(.DEPTH(DEPTH)) bus ();

    audio_sample_fifo #(
        .DEPTH     (DEPTH),
        .LOW_WATER (LW)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .fifo_bus (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] sb [$];
    int          m_level;
    logic        m_active;
    logic        m_play;
    logic        m_und;
    logic        m_ovf;
    logic [15:0] m_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_flush();
        sb.delete();
        m_level  = 0;
        m_active = 1'b0;
        m_play   = 1'b0;
        m_data   = 16'h0000;
    endtask

    // One clock with the given strobes; the model is advanced from pre-edge
    // state, then the DUT is sampled 1 time unit after the edge.
    task automatic step(input logic wr, input logic [15:0] d, input logic pop, input logic clr);
        logic pop_ok, wr_ok, und, ovf;
        bus.i_wr_en       = wr;
        bus.i_wr_data     = d;
        bus.i_next_sample = pop;
        bus.i_clr_flags   = clr;
        pop_ok = 1'b0;
        wr_ok  = 1'b0;
        und    = 1'b0;
        ovf    = 1'b0;
        if (!bus.i_enable) begin
            model_flush();
        end else if (!m_active) begin
            m_active = 1'b1;
        end else begin
            pop_ok = pop && m_play && (m_level > 0);
            und    = pop && m_play && (m_level == 0);
            wr_ok  = wr && ((m_level < DEPTH) || pop_ok);
            ovf    = wr && !wr_ok;
            if (pop_ok) m_data = sb.pop_front();
            if (und) begin
                m_data = 16'h0000;
                m_play = 1'b0;
            end
            if (wr_ok) sb.push_back(d);
            m_level = m_level + int'(wr_ok) - int'(pop_ok);
            if (!m_play && !und && (m_level >= LW)) m_play = 1'b1;
        end
        if (clr) begin
            m_und = 1'b0;
            m_ovf = 1'b0;
        end
        if (und) m_und = 1'b1;
        if (ovf) m_ovf = 1'b1;

        @(posedge Clk);
        #1;
        bus.i_wr_en       = 1'b0;
        bus.i_next_sample = 1'b0;
        bus.i_clr_flags   = 1'b0;

        check("level", 32'(bus.o_level), 32'(m_level));
        check("underrun", 32'(bus.o_underrun), 32'(m_und));
        check("overflow", 32'(bus.o_overflow), 32'(m_ovf));
        if (pop) check("data", {16'h0, bus.o_data}, {16'h0, m_data});
    endtask

    task automatic write(input logic [15:0] d);
        step(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, 16'h0000, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        bus.i_wr_en       = 1'b0;
        bus.i_next_sample = 1'b0;
        bus.i_clr_flags   = 1'b0;
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        model_flush();
        m_und = 1'b0;
        m_ovf = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_level"}, 32'(bus.o_level), 32'd0);
        check({tag, "_data"}, {16'h0, bus.o_data}, 32'd0);
        check({tag, "_empty"}, 32'(bus.o_empty), 32'd1);
        check({tag, "_full"}, 32'(bus.o_full), 32'd0);
        check({tag, "_irq"}, 32'(bus.o_low_water_irq), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.i_enable      = 1'b0;
        bus.i_wr_data     = '0;
        bus.i_wr_en       = 1'b0;
        bus.i_next_sample = 1'b0;
        bus.i_clr_flags   = 1'b0;
        m_und = 1'b0;
        m_ovf = 1'b0;
        model_flush();

        // Reset state
        Reset = 1'b1;
        @(posedge Clk);
        do_reset();
        check_idle_outputs("reset");
        check("reset_underrun", 32'(bus.o_underrun), 32'd0);
        check("reset_overflow", 32'(bus.o_overflow), 32'd0);

        // Prime: writes ignored in IDLE, pops ignored in PRIME
        bus.i_enable = 1'b1;
        step(1'b1, 16'hdead, 1'b0, 1'b0);
        check("prime_irq", 32'(bus.o_low_water_irq), 32'd1);
        for (int i = 1; i <= 10; i++) write(16'(i));
        pop();
        for (int i = 11; i <= 64; i++) write(16'(i));
        check("primed_level", 32'(bus.o_level), 32'd64);
        check("primed_irq", 32'(bus.o_low_water_irq), 32'd0);
        pop();
        check("first_data", {16'h0, bus.o_data}, 32'h0001);
        check("first_level", 32'(bus.o_level), 32'd63);

        // Underrun: drain to one, pop the last sample, then pop empty
        while (m_level > 1) pop();
        pop();
        check("last_data", {16'h0, bus.o_data}, 32'h0040);
        pop();
        check("underrun_data", {16'h0, bus.o_data}, 32'h0000);
        check("underrun_flag", 32'(bus.o_underrun), 32'd1);
        pop();
        check("starved_level", 32'(bus.o_level), 32'd0);
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        check("clr_underrun", 32'(bus.o_underrun), 32'd0);

        // Overflow: flush, then write DEPTH+1 samples
        bus.i_enable = 1'b0;
        step(1'b0, 16'h0000, 1'b0, 1'b0);
        check_idle_outputs("disable1");
        bus.i_enable = 1'b1;
        step(1'b0, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i <= DEPTH; i++) write(16'(16'h1000 + i));
        check("ovf_full", 32'(bus.o_full), 32'd1);
        check("ovf_level", 32'(bus.o_level), 32'd256);
        check("ovf_flag", 32'(bus.o_overflow), 32'd1);
        // Overflow event and clear in the same cycle: event wins
        step(1'b1, 16'h1fff, 1'b0, 1'b1);
        check("ovf_set_wins", 32'(bus.o_overflow), 32'd1);
        // Pop + write while full: both accepted, level unchanged
        step(1'b1, 16'h2000, 1'b1, 1'b0);
        check("full_popwr_level", 32'(bus.o_level), 32'd256);
        check("full_popwr_data", {16'h0, bus.o_data}, 32'h1000);
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        check("clr_overflow", 32'(bus.o_overflow), 32'd0);
        while (m_level > 0) pop();
        check("drained_empty", 32'(bus.o_empty), 32'd1);
        // Pop + write while empty in PLAY, with a clear: underrun wins, write kept
        step(1'b1, 16'h2100, 1'b1, 1'b1);
        check("empty_popwr_underrun", 32'(bus.o_underrun), 32'd1);
        check("empty_popwr_level", 32'(bus.o_level), 32'd1);
        check("empty_popwr_data", {16'h0, bus.o_data}, 32'h0000);

        // Wrap: stream 600 samples, popping once the level reaches 100
        for (int i = 0; i < 600; i++) begin
            step(1'b1, 16'(16'h3000 + i), (m_level >= 100), 1'b0);
        end
        check("stream_level", 32'(bus.o_level), 32'd100);

        // Reset mid-stream with ENABLE still high
        do_reset();
        check_idle_outputs("midreset");
        check("midreset_underrun", 32'(bus.o_underrun), 32'd0);
        check("midreset_overflow", 32'(bus.o_overflow), 32'd0);

        // Disable mid-stream at LEVEL=100
        step(1'b0, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) write(16'(16'h4000 + i));
        pop();
        pop();
        write(16'h4100);
        write(16'h4101);
        check("predisable_level", 32'(bus.o_level), 32'd100);
        check("predisable_data", {16'h0, bus.o_data}, 32'h4001);
        bus.i_enable = 1'b0;
        step(1'b0, 16'h0000, 1'b0, 1'b0);
        check_idle_outputs("disable2");

        // Re-enable: old samples must not reappear
        bus.i_enable = 1'b1;
        step(1'b0, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < LW; i++) write(16'(16'h5000 + i));
        pop();
        check("reenable_data", {16'h0, bus.o_data}, 32'h5000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
